// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers for the counter and its converter.
// Functions operate on WIDTH_MAX-wide vectors; narrower users zero-extend and truncate.
package gray_pkg;

    localparam int WIDTH_MAX = 32;

    function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    function automatic logic [WIDTH_MAX-1:0] gray2bin(input logic [WIDTH_MAX-1:0] gray);
        logic [WIDTH_MAX-1:0] bin;
        bin[WIDTH_MAX-1] = gray[WIDTH_MAX-1];
        for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control/status bundle for gray_counter.
// The wrapped flag exists only when GRAY_COUNTER_WRAP_FLAG_EN is defined.
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_q;
    logic             tc;
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
    logic             wrapped;

    modport master (
        output en, up, load, load_bin,
        input  gray_q, bin_q, tc, wrapped
    );

    modport slave (
        input  en, up, load, load_bin,
        output gray_q, bin_q, tc, wrapped
    );
`else
    modport master (
        output en, up, load, load_bin,
        input  gray_q, bin_q, tc
    );

    modport slave (
        input  en, up, load, load_bin,
        output gray_q, bin_q, tc
    );
`endif
endinterface

// File: rtl/gray_bin_conv.sv
// Combinational binary-to-Gray converter, WIDTH-scalable up to gray_pkg::WIDTH_MAX.
module gray_bin_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin2gray(WIDTH_MAX'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with registered Gray and binary outputs, sync load and terminal count.
// Optional sticky wrap flag under GRAY_COUNTER_WRAP_FLAG_EN.
module gray_counter
    import gray_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter logic [31:0] RESET_BIN = 32'd0
) (
    input  logic          clk,
    input  logic          rst,
    gray_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] RESET_VAL = RESET_BIN[WIDTH-1:0];

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             at_max;
    logic             at_min;
    logic             tc;

    assign at_max = &bin_r;
    assign at_min = ~|bin_r;
    assign tc     = bus.en & ((bus.up & at_max) | (~bus.up & at_min));

    // rst > load > en > hold; the reset value goes through the same path so
    // the Gray register always tracks the binary register on the same edge.
    always_comb begin
        next_bin = bin_r;
        if (rst) begin
            next_bin = RESET_VAL;
        end else if (bus.load) begin
            next_bin = bus.load_bin;
        end else if (bus.en) begin
            next_bin = bus.up ? bin_r + 1'b1 : bin_r - 1'b1;
        end
    end

    gray_bin_conv #(
        .WIDTH(WIDTH)
    ) u_conv (
        .bin (next_bin),
        .gray(next_gray)
    );

    always_ff @(posedge clk) begin
        bin_r  <= next_bin;
        gray_r <= next_gray;
    end

    assign bus.bin_q  = bin_r;
    assign bus.gray_q = gray_r;
    assign bus.tc     = tc;

`ifdef GRAY_COUNTER_WRAP_FLAG_EN
    logic wrapped_r;

    // A counting step wraps exactly when tc is high and no load/rst overrides it.
    always_ff @(posedge clk) begin
        if (rst || bus.load) begin
            wrapped_r <= 1'b0;
        end else if (tc) begin
            wrapped_r <= 1'b1;
        end
    end

    assign bus.wrapped = wrapped_r;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Table-driven directed bench for gray_counter (WIDTH=4, RESET_BIN=0).
// Wrap-flag sequences run only when GRAY_COUNTER_WRAP_FLAG_EN is defined.
module tb_gray_counter;

    localparam int WIDTH = 4;

    typedef struct {
        logic       rst;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] load_bin;
        logic       exp_tc;
        logic [3:0] exp_bin;
        logic [3:0] exp_gray;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gray_counter_if #(.WIDTH(WIDTH)) bus ();

    gray_counter #(
        .WIDTH    (WIDTH),
        .RESET_BIN(32'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    vec_t vecs[64];
    int   nvec   = 0;
    int   errors = 0;
    int   checks = 0;

    logic [3:0] gray_seq[16];

    task automatic add(input logic r, input logic ld, input logic e, input logic u,
                       input logic [3:0] lb, input logic etc,
                       input logic [3:0] eb, input logic [3:0] eg);
        vecs[nvec].rst      = r;
        vecs[nvec].load     = ld;
        vecs[nvec].en       = e;
        vecs[nvec].up       = u;
        vecs[nvec].load_bin = lb;
        vecs[nvec].exp_tc   = etc;
        vecs[nvec].exp_bin  = eb;
        vecs[nvec].exp_gray = eg;
        nvec++;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_g2b(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic drive(input logic r, input logic ld, input logic e, input logic u,
                         input logic [3:0] lb);
        rst          = r;
        bus.load     = ld;
        bus.en       = e;
        bus.up       = u;
        bus.load_bin = lb;
    endtask

    initial begin
        logic [3:0] prev_gray;
        gray_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        // reset, then a full up cycle through all 16 codes and back to 0
        add(1, 0, 0, 0, 4'h0, 0, 4'h0, 4'b0000);
        for (int i = 0; i < 16; i++)
            add(0, 0, 1, 1, 4'h0, (i == 15), 4'((i + 1) % 16), gray_seq[(i + 1) % 16]);
        // down from reset value: tc in the same cycle, wrap to all ones
        add(1, 0, 0, 0, 4'h0, 0, 4'h0, 4'b0000);
        add(0, 0, 1, 0, 4'h0, 1, 4'hF, 4'b1000);
        // load beats en; tc still reflects en/up/bin_q=1111 in that cycle
        add(0, 1, 1, 1, 4'b1001, 1, 4'b1001, 4'b1101);
        add(0, 0, 1, 1, 4'h0,    0, 4'b1010, 4'b1111);
        // down to 0110 with a direction change of up front
        add(0, 0, 1, 0, 4'h0, 0, 4'b1001, 4'b1101);
        add(0, 0, 1, 0, 4'h0, 0, 4'b1000, 4'b1100);
        add(0, 0, 1, 0, 4'h0, 0, 4'b0111, 4'b0100);
        add(0, 0, 1, 0, 4'h0, 0, 4'b0110, 4'b0101);
        // hold three cycles with up toggling
        add(0, 0, 0, 1, 4'h0, 0, 4'b0110, 4'b0101);
        add(0, 0, 0, 0, 4'h0, 0, 4'b0110, 4'b0101);
        add(0, 0, 0, 1, 4'h0, 0, 4'b0110, 4'b0101);
        // rst with load and en asserted
        add(1, 1, 1, 1, 4'hF, 0, 4'b0000, 4'b0000);
        // direction flips around zero; tc gated by en
        add(0, 0, 1, 1, 4'h0, 0, 4'b0001, 4'b0001);
        add(0, 0, 1, 0, 4'h0, 0, 4'b0000, 4'b0000);
        add(0, 0, 0, 0, 4'h0, 0, 4'b0000, 4'b0000);
        add(0, 0, 1, 0, 4'h0, 1, 4'b1111, 4'b1000);
        add(0, 0, 1, 1, 4'h0, 1, 4'b0000, 4'b0000);
        // load without en, then load of all ones
        add(0, 1, 0, 0, 4'b0101, 0, 4'b0101, 4'b0111);
        add(0, 1, 0, 1, 4'b1111, 0, 4'b1111, 4'b1000);
        add(0, 0, 1, 0, 4'h0,    0, 4'b1110, 4'b1001);

        drive(0, 0, 0, 0, 4'h0);
        prev_gray = 4'h0;
        @(negedge clk);
        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].load_bin);
            #1;
            check("tc", i, 32'(bus.tc), 32'(vecs[i].exp_tc));
            prev_gray = bus.gray_q;
            @(posedge clk);
            #1;
            check("bin_q", i, 32'(bus.bin_q), 32'(vecs[i].exp_bin));
            check("gray_q", i, 32'(bus.gray_q), 32'(vecs[i].exp_gray));
            check("bin_eq_gray2bin", i, 32'(bus.bin_q), 32'(ref_g2b(bus.gray_q)));
            if (i > 0 && !vecs[i].rst && !vecs[i].load && !vecs[i-1].rst)
                check("gray_bits_changed", i, 32'($countones(bus.gray_q ^ prev_gray)),
                      32'(vecs[i].en ? 1 : 0));
        end

`ifdef GRAY_COUNTER_WRAP_FLAG_EN
        drive(1, 0, 0, 0, 4'h0);
        @(posedge clk); #1;
        check("wrapped_rst", 0, 32'(bus.wrapped), 32'd0);
        drive(0, 1, 0, 0, 4'b1110);
        @(posedge clk); #1;
        check("wrapped_load", 1, 32'(bus.wrapped), 32'd0);
        drive(0, 0, 1, 1, 4'h0);
        @(posedge clk); #1;
        check("wrapped_1111", 2, 32'(bus.wrapped), 32'd0);
        @(posedge clk); #1;
        check("wrapped_up_wrap", 3, 32'(bus.wrapped), 32'd1);
        check("wrap_bin", 3, 32'(bus.bin_q), 32'd0);
        @(posedge clk); #1;
        check("wrapped_sticky", 4, 32'(bus.wrapped), 32'd1);
        drive(0, 1, 0, 0, 4'b0011);
        @(posedge clk); #1;
        check("wrapped_load_clr", 5, 32'(bus.wrapped), 32'd0);
        drive(0, 1, 0, 0, 4'b0000);
        @(posedge clk); #1;
        drive(0, 0, 1, 0, 4'h0);
        @(posedge clk); #1;
        check("wrapped_down_wrap", 6, 32'(bus.wrapped), 32'd1);
        check("wrap_down_bin", 6, 32'(bus.bin_q), 32'hF);
        drive(0, 1, 0, 0, 4'b1111);
        @(posedge clk); #1;
        drive(0, 1, 1, 1, 4'b0100);
        @(posedge clk); #1;
        check("wrapped_load_vs_wrap", 7, 32'(bus.wrapped), 32'd0);
        check("load_vs_wrap_bin", 7, 32'(bus.bin_q), 32'd4);
`endif

        drive(0, 0, 0, 0, 4'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
